// File: rtl/clock_divider_pkg.sv
// Shared constants and helpers for the multi-channel clock-enable generator.
package clock_pkg;

  localparam int DEF_DIV = 8;
  localparam int MIN_DIV = 2;

  // Width of a channel-select field; a single channel still gets one bit.
  function automatic int ld_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Number of high cycles in one divided-clock period.
  function automatic logic [31:0] half(input logic [31:0] div);
    return div >> 1;
  endfunction

endpackage

// File: rtl/clock_channel.sv
// One divider slice: period counter, active/shadow divisor pair and registered decode.
module clock_channel
  import clock_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = clock_pkg::DEF_DIV
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] ld_div_i,
  output logic             clk_out_o,
  output logic             tick_o,
  output logic             pend_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic [CNT_W-1:0] div_shd_q, div_shd_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             run;
  logic             wrap;
  logic [CNT_W-1:0] half_div;

  // Divisors below MIN_DIV park the channel exactly as a deasserted enable would.
  assign run      = en_i && (div_act_q >= CNT_W'(MIN_DIV));
  assign wrap     = (cnt_q == (div_act_q - CNT_W'(1)));
  assign half_div = CNT_W'(half(32'(div_act_q)));

  always_comb begin
    cnt_d     = cnt_q;
    div_act_d = div_act_q;
    div_shd_d = div_shd_q;
    pend_d    = pend_q;
    tick_d    = run && (cnt_q == '0);
    clk_d     = run && (cnt_q < half_div);

    if (!run) begin
      cnt_d = '0;
      if (load_i) begin
        div_act_d = ld_div_i;
        pend_d    = 1'b0;
      end
    end else if (wrap || sync_i) begin
      // Period boundary: a same-cycle load beats an older shadowed value.
      cnt_d = '0;
      if (load_i) begin
        div_act_d = ld_div_i;
      end else if (pend_q) begin
        div_act_d = div_shd_q;
      end
      pend_d = 1'b0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      if (load_i) begin
        div_shd_d = ld_div_i;
        pend_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      div_act_q <= CNT_W'(DEF_DIV);
      div_shd_q <= CNT_W'(DEF_DIV);
      pend_q    <= 1'b0;
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_act_q <= div_act_d;
      div_shd_q <= div_shd_d;
      pend_q    <= pend_d;
      clk_q     <= clk_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out_o = clk_q;
  assign tick_o    = tick_q;
  assign pend_o    = pend_q;

endmodule

// File: rtl/clock_divider.sv
// Multi-channel clock-enable generator: decodes divisor writes and fans out sync to N_CH slices.
module clock_divider
  import clock_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = clock_pkg::DEF_DIV
) (
  input  logic                      clock,
  input  logic                      reset_,
  input  logic [N_CH-1:0]           en,
  input  logic                      sync,
  input  logic                      load,
  input  logic [ld_width(N_CH)-1:0] ld_ch,
  input  logic [CNT_W-1:0]          ld_div,
  output logic [N_CH-1:0]           clk_out,
  output logic [N_CH-1:0]           tick,
  output logic [N_CH-1:0]           pend
);

  logic [N_CH-1:0] ld_hit;

  // An out-of-range ld_ch matches no slice, so the write is dropped.
  always_comb begin
    ld_hit = '0;
    for (int i = 0; i < N_CH; i++) begin
      ld_hit[i] = load && (int'(ld_ch) == i);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    clock_channel #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk_i     (clock),
      .rst_ni    (reset_),
      .en_i      (en[g]),
      .sync_i    (sync),
      .load_i    (ld_hit[g]),
      .ld_div_i  (ld_div),
      .clk_out_o (clk_out[g]),
      .tick_o    (tick[g]),
      .pend_o    (pend[g])
    );
  end

endmodule

// File: tb/tb_clock_divider.sv
// Self-checking bench for clock_divider: time-based period model plus directed literal checks.
module tb_clock_divider;

  localparam int N_CH  = 4;
  localparam int CNT_W = 8;
  localparam int DEFD  = 8;

  logic              clock;
  logic              reset_;
  logic [N_CH-1:0]   en;
  logic              sync;
  logic              load;
  logic [1:0]        ld_ch;
  logic [CNT_W-1:0]  ld_div;
  logic [N_CH-1:0]   clk_out;
  logic [N_CH-1:0]   tick;
  logic [N_CH-1:0]   pend;

  int errors = 0;
  int checks = 0;

  clock_divider #(.N_CH(N_CH), .CNT_W(CNT_W), .DEF_DIV(DEFD)) dut (
    .clock   (clock),
    .reset_  (reset_),
    .en      (en),
    .sync    (sync),
    .load    (load),
    .ld_ch   (ld_ch),
    .ld_div  (ld_div),
    .clk_out (clk_out),
    .tick    (tick),
    .pend    (pend)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [N_CH-1:0] act, input logic [N_CH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each channel remembers the cycle its current period began.
  longint now = 0;
  longint m_start[N_CH];
  int     m_da[N_CH];
  int     m_ds[N_CH];
  bit     m_pend[N_CH];
  logic [3*N_CH-1:0] exp_q[$];

  always @(posedge clock) begin
    logic [N_CH-1:0] et, ec, ep;
    bit     run, ld;
    longint ph;
    et = '0; ec = '0; ep = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!reset_) begin
        m_da[i] = DEFD; m_ds[i] = DEFD; m_pend[i] = 0; m_start[i] = now + 1;
      end else begin
        run = en[i] && (m_da[i] >= 2);
        ld  = load && (int'(ld_ch) == i);
        ph  = now - m_start[i];
        et[i] = run && (ph == 0);
        ec[i] = run && (ph < longint'(m_da[i] / 2));
        if (!run) begin
          m_start[i] = now + 1;
          if (ld) begin m_da[i] = int'(ld_div); m_pend[i] = 0; end
        end else if (ph == longint'(m_da[i] - 1) || sync) begin
          m_start[i] = now + 1;
          if (ld) m_da[i] = int'(ld_div);
          else if (m_pend[i]) m_da[i] = m_ds[i];
          m_pend[i] = 0;
        end else if (ld) begin
          m_ds[i] = int'(ld_div); m_pend[i] = 1;
        end
      end
      ep[i] = m_pend[i];
    end
    exp_q.push_back({et, ec, ep});
    now++;
  end

  // scoreboard compare
  always @(negedge clock) begin
    logic [3*N_CH-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("model_tick", tick, e[3*N_CH-1:2*N_CH]);
      check("model_clk_out", clk_out, e[2*N_CH-1:N_CH]);
      check("model_pend", pend, e[N_CH-1:0]);
    end
  end

  // driver tasks
  task automatic wait_n(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive_load(input int ch, input int d);
    load = 1'b1; ld_ch = 2'(ch); ld_div = CNT_W'(d);
  endtask

  task automatic clear_strobes();
    load = 1'b0; sync = 1'b0;
  endtask

  initial begin
    reset_ = 1'b0; en = '0; sync = 1'b0; load = 1'b0; ld_ch = '0; ld_div = '0;
    wait_n(3);
    reset_ = 1'b1; en = 4'hF;
    // Default period 8, all channels in phase.
    wait_n(1);  check("first_tick", tick, 4'hF); check("first_clk", clk_out, 4'hF); check("pend_idle", pend, 4'h0);
    wait_n(1);  check("tick_gap", tick, 4'h0); check("clk_high2", clk_out, 4'hF);
    wait_n(3);  check("clk_low", clk_out, 4'h0);
    wait_n(4);  check("tick_p8", tick, 4'hF);
    // ch1 -> 5 mid-period
    wait_n(2);  drive_load(1, 5);
    wait_n(1);  clear_strobes(); check("pend_ch1_set", pend, 4'b0010);
    wait_n(3);  check("pend_ch1_hold", pend, 4'b0010);
    wait_n(1);  check("pend_ch1_clear", pend, 4'b0000);
    wait_n(1);  check("tick_e17", tick, 4'hF);
    wait_n(1);  check("ch1_clk_high", clk_out & 4'b0010, 4'b0010);
    wait_n(1);  check("ch1_clk_low", clk_out & 4'b0010, 4'b0000);
    wait_n(3);  check("ch1_tick_p5", tick, 4'b0010);
    // ch2 -> 3 on its wrap cycle
    wait_n(1);  drive_load(2, 3);
    wait_n(1);  clear_strobes(); check("ch2_no_pend", pend, 4'b0000);
    wait_n(1);  check("tick_e25", tick, 4'b1101);
    wait_n(3);  check("ch2_tick_p3", tick, 4'b0100);
    // ch0 halt with divisor 1 then 0, restart with 6
    drive_load(0, 1);
    wait_n(1);  clear_strobes();
    wait_n(6);  check("halt_tick", tick & 4'b0001, 4'b0000); check("halt_clk", clk_out & 4'b0001, 4'b0000);
                check("halt_pend", pend & 4'b0001, 4'b0000);
    drive_load(0, 0);
    wait_n(1);  drive_load(0, 6);
    wait_n(1);  clear_strobes();
    wait_n(1);  check("ch0_restart_tick", tick & 4'b0001, 4'b0001); check("ch0_restart_clk", clk_out & 4'b0001, 4'b0001);
    wait_n(5);  check("ch0_p6_gap", tick & 4'b0001, 4'b0000);
    wait_n(1);  check("ch0_p6_tick", tick & 4'b0001, 4'b0001);
    // divisors 4/6/7 then sync
    drive_load(1, 4);
    wait_n(1);  drive_load(2, 6);
    wait_n(1);  drive_load(3, 7);
    wait_n(1);  clear_strobes();
    wait_n(20); sync = 1'b1;
    wait_n(1);  sync = 1'b0;
    wait_n(1);  check("sync_align", tick, 4'hF);
    wait_n(4);  check("sync_p4", tick, 4'b0010);
    wait_n(2);  check("sync_p6", tick, 4'b0101);
    wait_n(1);  check("sync_p7", tick, 4'b1000);
    wait_n(1);  check("sync_p4b", tick, 4'b0010);
    // reset mid-run with a pending load
    drive_load(1, 9);
    wait_n(1);  clear_strobes(); check("pend_before_rst", pend, 4'b0010); reset_ = 1'b0;
    wait_n(1);  reset_ = 1'b1; check("rst_tick", tick, 4'h0); check("rst_clk", clk_out, 4'h0); check("rst_pend", pend, 4'h0);
    wait_n(1);  check("post_rst_tick", tick, 4'hF);
    wait_n(4);  check("post_rst_clk_low", clk_out, 4'h0);
    wait_n(4);  check("post_rst_p8", tick, 4'hF);
    // random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      load   = ($urandom_range(0, 5) == 0);
      ld_ch  = 2'($urandom_range(0, 3));
      ld_div = CNT_W'($urandom_range(0, 20));
      sync   = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 30) == 0) en = 4'($urandom_range(0, 15));
      reset_ = ($urandom_range(0, 600) != 0);
      wait_n(1);
    end
    clear_strobes(); reset_ = 1'b1;
    wait_n(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
